// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data-memory accesses: alignment check, byte enables,
// store-data replication and load extraction with sign/zero extension.
module mem_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  input  logic        load_unsigned,
  output logic        aligned,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_value
);
  import mips_mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = read_word[7:0];
    case (addr_lo)
      2'd0: byte_sel = read_word[7:0];
      2'd1: byte_sel = read_word[15:8];
      2'd2: byte_sel = read_word[23:16];
      2'd3: byte_sel = read_word[31:24];
      default: byte_sel = read_word[7:0];
    endcase
    half_sel = addr_lo[1] ? read_word[31:16] : read_word[15:0];
  end

  // Size 2'b11 falls into the default branch and behaves as a word.
  always_comb begin
    aligned    = (addr_lo == 2'b00);
    byte_en    = 4'b1111;
    lane_wdata = store_data;
    load_value = read_word;
    case (size)
      SIZE_BYTE: begin
        aligned    = 1'b1;
        byte_en    = 4'b0001 << addr_lo;
        lane_wdata = {4{store_data[7:0]}};
        load_value = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        aligned    = ~addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
        load_value = {{16{~load_unsigned & half_sel[15]}}, half_sel};
      end
      default: begin
        aligned    = (addr_lo == 2'b00);
        byte_en    = 4'b1111;
        lane_wdata = store_data;
        load_value = read_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: req/ack bus transaction, pipeline stall,
// load extraction. Optional bus timeout is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = mips_mem_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  accessSize,
  input  logic        loadUnsigned,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busByteEn,
  input  logic [31:0] busRData,
  input  logic        busAck,
  output logic [31:0] memReadData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError
);
  import mips_mem_pkg::*;

  state_t      state;
  state_t      next_state;
  logic        access;
  logic        aligned;
  logic        start;
  logic        ack_done;
  logic        timeout_hit;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_value;

  mem_lane_align u_lane (
    .size          (accessSize),
    .addr_lo       (address[1:0]),
    .store_data    (storeData),
    .read_word     (busRData),
    .load_unsigned (loadUnsigned),
    .aligned       (aligned),
    .byte_en       (lane_be),
    .lane_wdata    (lane_wdata),
    .load_value    (load_value)
  );

  assign access   = MemReadIn | MemWriteIn;
  assign start    = (state == ST_IDLE) & access & aligned;
  assign ack_done = (state == ST_WAIT) & busAck;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_count;

  // Counts completed WAIT cycles; the last allowed cycle without an ack times out.
  assign timeout_hit = (state == ST_WAIT) & ~busAck &
                       (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || start) begin
      wait_count <= '0;
    end else if (state == ST_WAIT) begin
      wait_count <= wait_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busError <= 1'b0;
    end else begin
      busError <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Evaluates to 0 for any legal TIMEOUT_CYCLES; no timeout hardware exists here.
  assign busError    = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        misaligned = access & ~aligned;
        if (start) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (busAck || timeout_hit) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    stall = ~reset & (start | (state == ST_WAIT));
  end

  // Bus outputs are captured once per transaction and held until ack or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      busReq      <= 1'b0;
      busWe       <= 1'b0;
      busAddr     <= '0;
      busWData    <= '0;
      busByteEn   <= '0;
      memReadData <= '0;
    end else begin
      if (start) begin
        busReq    <= 1'b1;
        busWe     <= MemWriteIn;
        busAddr   <= {address[31:2], 2'b00};
        busWData  <= lane_wdata;
        busByteEn <= lane_be;
      end else if (ack_done || timeout_hit) begin
        busReq <= 1'b0;
        busWe  <= 1'b0;
      end
      if (ack_done && !busWe) begin
        memReadData <= load_value;
      end else if (timeout_hit) begin
        memReadData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// accesses checked against a byte-level reference model.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadIn = 1'b0;
  logic        MemWriteIn = 1'b0;
  logic [1:0]  accessSize = 2'b00;
  logic        loadUnsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] storeData = '0;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busByteEn;
  logic [31:0] busRData = '0;
  logic        busAck = 1'b0;
  logic [31:0] memReadData;
  logic        stall;
  logic        misaligned;
  logic        busError;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemReadIn    (MemReadIn),
    .MemWriteIn   (MemWriteIn),
    .accessSize   (accessSize),
    .loadUnsigned (loadUnsigned),
    .address      (address),
    .storeData    (storeData),
    .busReq       (busReq),
    .busWe        (busWe),
    .busAddr      (busAddr),
    .busWData     (busWData),
    .busByteEn    (busByteEn),
    .busRData     (busRData),
    .busAck       (busAck),
    .memReadData  (memReadData),
    .stall        (stall),
    .misaligned   (misaligned),
    .busError     (busError)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          req_rises = 0;
  int          exp_reqs = 0;
  logic        req_q = 1'b0;
  logic [31:0] exp_rd = '0;

  always @(negedge clk) begin
    if (busReq === 1'b1 && req_q !== 1'b1) req_rises++;
    req_q = busReq;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_aligned(input logic [1:0] s, input logic [31:0] a);
    return (int'(a % 4) % nbytes(s)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
    int v;
    v = ((1 << nbytes(s)) - 1) << int'(a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = nbytes(s);
    v = rd >> (8 * int'(a % 4));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = v & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] sd);
    MemReadIn    = rd;
    MemWriteIn   = wr;
    accessSize   = size;
    loadUnsigned = uns;
    address      = addr;
    storeData    = sd;
  endtask

  // Called at a sample point with the FSM idle; returns at the IDLE cycle after DONE.
  task automatic do_access(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdata, input int ack_cycle);
    apply_stimulus(rd, wr, size, uns, addr, sd);
    busAck = 1'b0;
    #1;
    if (!model_aligned(size, addr)) begin
      check_output({tag, "_misaligned"}, {31'd0, misaligned}, 32'd1);
      check_output({tag, "_mis_stall"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      check_output({tag, "_mis_noreq"}, {31'd0, busReq}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
      return;
    end
    check_output({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
    check_output({tag, "_nomis"}, {31'd0, misaligned}, 32'd0);
    exp_reqs++;
    for (int c = 1; c <= ack_cycle; c++) begin
      @(posedge clk); #1;
      check_output({tag, "_req"}, {31'd0, busReq}, 32'd1);
      check_output({tag, "_we"}, {31'd0, busWe}, {31'd0, wr});
      check_output({tag, "_stall_w"}, {31'd0, stall}, 32'd1);
      if (c == 1) begin
        check_output({tag, "_addr"}, busAddr, {addr[31:2], 2'b00});
        check_output({tag, "_be"}, {28'd0, busByteEn}, {28'd0, model_be(size, addr)});
        if (wr) check_output({tag, "_wdata"}, busWData, model_wdata(size, sd));
      end
      if (c == ack_cycle) begin
        busAck   = 1'b1;
        busRData = rdata;
      end
    end
    @(posedge clk); #1;
    busAck   = 1'b0;
    busRData = $urandom;
    if (rd && !wr) exp_rd = model_load(size, uns, addr, rdata);
    check_output({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    check_output({tag, "_done_req"}, {31'd0, busReq}, 32'd0);
    check_output({tag, "_rdata"}, memReadData, exp_rd);
    check_output({tag, "_buserr"}, {31'd0, busError}, 32'd0);
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  initial begin
    int pulses_before;
    logic [31:0] junk;

    // Reset: registers cleared, stall forced low even with a pending access.
    @(posedge clk); #1;
    check_output("rst_req", {31'd0, busReq}, 32'd0);
    check_output("rst_we", {31'd0, busWe}, 32'd0);
    check_output("rst_addr", busAddr, 32'd0);
    check_output("rst_wdata", busWData, 32'd0);
    check_output("rst_be", {28'd0, busByteEn}, 32'd0);
    check_output("rst_rdata", memReadData, 32'd0);
    check_output("rst_buserr", {31'd0, busError}, 32'd0);
    apply_stimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1);
    #1;
    check_output("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_output("rst_noreq", {31'd0, busReq}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_access("sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, '0, 1);
    do_access("lb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, '0, 32'h8000_0000, 4);
    check_output("lb_value", memReadData, 32'hFFFF_FF80);
    do_access("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, '0, 32'h8000_0000, 4);
    check_output("lbu_value", memReadData, 32'h0000_0080);

    // An ack while idle must not disturb the load result.
    busAck = 1'b1; busRData = 32'h5555_AAAA;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(posedge clk); #1;
    check_output("idle_ack", memReadData, 32'h0000_0080);

    do_access("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234, '0, 1);
    do_access("lh_mis", 1'b1, 1'b0, 2'b01, 1'b0, 32'h201, '0, '0, 1);

    pulses_before = req_rises;
    do_access("lw_a", 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, '0, 32'h1357_9BDF, 1);
    do_access("lw_b", 1'b1, 1'b0, 2'b11, 1'b0, 32'h304, '0, 32'h2468_ACE0, 1);
    check_output("b2b_pulses", req_rises - pulses_before, 32'd2);

    // Reset while waiting; the late ack must be ignored.
    apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, '0);
    #1;
    exp_reqs++;
    @(posedge clk); #1;
    check_output("rw_req", {31'd0, busReq}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("rw_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = '0;
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    busAck = 1'b1; busRData = 32'hCAFE_F00D;
    check_output("rw_req_drop", {31'd0, busReq}, 32'd0);
    @(posedge clk); #1;
    busAck = 1'b0;
    check_output("rw_rdata", memReadData, 32'd0);
    check_output("rw_idle_stall", {31'd0, stall}, 32'd0);
    check_output("rw_idle_req", {31'd0, busReq}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] sz;
      logic [31:0] a;
      logic rd_op;
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd0) ? a[1:0] : (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
      rd_op = 1'($urandom_range(0, 1));
      junk = $urandom;
      do_access("rnd", rd_op, ~rd_op, sz, 1'($urandom_range(0, 1)), a, $urandom, junk,
                $urandom_range(1, 3));
    end

`ifdef MEM_TIMEOUT_EN
    apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, '0);
    #1;
    exp_reqs++;
    for (int c = 1; c <= TO; c++) begin
      @(posedge clk); #1;
      check_output("to_req", {31'd0, busReq}, 32'd1);
      check_output("to_err_low", {31'd0, busError}, 32'd0);
      check_output("to_stall", {31'd0, stall}, 32'd1);
    end
    @(posedge clk); #1;
    exp_rd = '0;
    check_output("to_err", {31'd0, busError}, 32'd1);
    check_output("to_rdata", memReadData, 32'd0);
    check_output("to_release", {31'd0, stall}, 32'd0);
    check_output("to_req_drop", {31'd0, busReq}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(posedge clk); #1;
    check_output("to_err_pulse", {31'd0, busError}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check_output("req_total", req_rises, exp_reqs);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage data-memory access unit of the 5-stage MIPS pipeline, between the EX/MEM and MEM/WB pipeline registers. It turns the EX/MEM load/store controls into a request/acknowledge transaction on the data-memory bus. It aligns store data into byte lanes and extracts and extends load data. It produces the `memReadData` word captured by MEM/WB, and stalls the pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of WAIT cycles before a bus error is declared (used only with `MEM_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `MemReadIn` in 1: load in MEM stage (from EX/MEM).
- `MemWriteIn` in 1: store in MEM stage (from EX/MEM).
- `accessSize` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `loadUnsigned` in 1: zero-extend loads (lbu/lhu) when 1; sign-extend when 0.
- `address` in 32: byte address (ALU result).
- `storeData` in 32: rt value to store.
- `busReq` out 1: memory request, registered.
- `busWe` out 1: write request, registered.
- `busAddr` out 32: word address, `{address[31:2],2'b00}`, registered.
- `busWData` out 32: lane-replicated store data, registered.
- `busByteEn` out 4: byte enables, little-endian, registered.
- `busRData` in 32: read word from memory, valid when `busAck` is 1.
- `busAck` in 1: one-cycle acknowledge.
- `memReadData` out 32: extended load result, registered, to MEM/WB `memReadDataIn`.
- `stall` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB.
- `misaligned` out 1: combinational address-error flag.
- `busError` out 1: registered timeout flag.

## Operation
- FSM states: IDLE, WAIT, DONE.
- `access` = `MemReadIn | MemWriteIn`.
- `aligned` = byte always; half requires `address[0]`=0; word requires `address[1:0]`=0.
- IDLE, with `access & aligned`:
  - latch the bus outputs and set `busReq`=1 and `busWe`=`MemWriteIn`;
  - go to WAIT.
- IDLE, with `access & !aligned`:
  - `misaligned`=1 this cycle; no bus activity;
  - `stall`=0; FSM stays in IDLE.
- WAIT, with `busAck`=1:
  - clear `busReq` and `busWe`;
  - on a read, load `memReadData` with the extracted value;
  - go to DONE.
- WAIT, with `busAck`=0: hold all bus outputs stable.
- DONE: unconditionally go to IDLE. The EX/MEM inputs still show the completed instruction and are ignored.
- `stall` = `(IDLE & access & aligned) | WAIT`. It is forced to 0 while `reset` is 1.
- Byte enables:
  - byte: `4'b0001 << address[1:0]`;
  - half: `address[1]` ? 1100 : 0011;
  - word: 1111.
- Store data: byte `{4{storeData[7:0]}}`, half `{2{storeData[15:0]}}`, word as-is.
- Load extraction: select the byte lane `address[1:0]` or the half lane `address[1]` of `busRData`. Sign- or zero-extend per `loadUnsigned`; a word is passed through.
- `memReadData` holds its value except on a read acknowledge (or a timeout). Stores never change it.
- A `busAck` seen in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; `busReq`, `busWe`, `busError` 0; `busAddr`, `busWData`, `busByteEn`, `memReadData` 0.
- Access timing: request seen in cycle 0 (stall=1); `busReq` high from cycle 1; ack in cycle k≥1; DONE in cycle k+1 with stall=0; the pipeline advances at the end of k+1.
- Minimum access time: 3 cycles (zero-wait memory acks in cycle 1).
- `memReadData` is valid during DONE, when MEM/WB captures it.
- Back-to-back accesses: the next instruction is seen in the IDLE cycle after DONE.
- Reset mid-WAIT: `busReq` drops at that edge; a late ack is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - an 8+ bit counter is cleared on entry to WAIT and increments each WAIT cycle;
  - when it reaches `TIMEOUT_CYCLES` without an ack: clear `busReq`, set `memReadData`=0, go to DONE;
  - `busError`=1 for that DONE cycle only.
- `MEM_TIMEOUT_EN` undefined: WAIT lasts indefinitely; `busError` is constant 0; no counter is built.

## Structure
- Package `mips_mem_pkg`:
  - size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`;
  - FSM state constants;
  - default `TIMEOUT_CYCLES`.
- Sub-module `mem_lane_align` (combinational): alignment check, byte-enable generation, store replication and load extraction. The FSM, counter and registers stay in the top module.

## Test plan
- sw 0xDEADBEEF at 0x100, ack in cycle 1 → `busByteEn`=1111, `busWe`=1, `busAddr`=0x100; stall high for cycles 0–1, low in cycle 2.
- lb at 0x103, busRData=0x80000000, ack after 4 wait cycles → `memReadData`=0xFFFFFF80; with lbu → 0x00000080; stall high for 5 cycles.
- sh 0x1234 at 0x202 → `busByteEn`=1100, `busWData`=0x12341234; lh at 0x201 → `misaligned`=1, `busReq` stays 0, stall=0.
- Two consecutive lw, each acked in cycle 1 → exactly two `busReq` pulses, 3 cycles per access, no duplicate request in DONE.
- reset asserted in WAIT, then ack the next cycle → `busReq`=0 after the reset edge; `memReadData` stays 0; FSM in IDLE.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `busError` pulses 1 after the 4th WAIT cycle; `memReadData`=0; stall released.
